memory_stage_lsu: RTL

// Memory (M) stage of the 5-stage RV32I pipeline; consumes the E->M pipeline register outputs.

---
 rtl/pipeline_pkg.sv | 36 +++
 rtl/memory_stage_lsu_if.sv | 21 ++
 rtl/lsu_align.sv | 56 +++++
 rtl/memory_stage_lsu_chk.sv | 27 ++
 rtl/memory_stage_lsu.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared types for the memory stage: result-source encoding, load/store
// size codes (funct3), LSU handshake states and the misalignment rule.
package pipeline_pkg;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10
    } result_src_e;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'b00,
        ST_WAIT_GNT    = 2'b01,
        ST_WAIT_RVALID = 2'b10
    } lsu_state_e;

    // Halfwords need an even address, words a multiple of four; bytes never misalign.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic r;
        case (funct3)
            MEM_H, MEM_HU: r = addr_lo[0];
            MEM_W:         r = (addr_lo != 2'b00);
            default:       r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/memory_stage_lsu_if.sv
// Data-memory request/grant/response bus between the LSU (master) and memory (slave).
interface memory_stage_lsu_if #(parameter int XLEN = 32);
    logic              dmem_req;
    logic              dmem_we;
    logic [XLEN-1:0]   dmem_addr;
    logic [XLEN/8-1:0] dmem_be;
    logic [XLEN-1:0]   dmem_wdata;
    logic              dmem_gnt;
    logic              dmem_rvalid;
    logic [XLEN-1:0]   dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: replicates store data into byte lanes with
// matching byte enables, and extracts/extends load data from the raw word.
module lsu_align
    import pipeline_pkg::*;
(
    input  logic [2:0]  i_st_funct3,
    input  logic [1:0]  i_st_addr_lo,
    input  logic [31:0] i_st_data,
    output logic [3:0]  o_st_be,
    output logic [31:0] o_st_wdata,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic [31:0] i_ld_rdata,
    output logic [31:0] o_ld_data
);
    logic [31:0] w_shifted;

    assign w_shifted = i_ld_rdata >> {i_ld_addr_lo, 3'b000};

    // Store: replicate the low bytes across the word and enable the addressed lanes.
    always_comb begin
        o_st_be    = 4'b0000;
        o_st_wdata = i_st_data;
        case (i_st_funct3)
            MEM_B: begin
                o_st_be    = 4'b0001 << i_st_addr_lo;
                o_st_wdata = {4{i_st_data[7:0]}};
            end
            MEM_H: begin
                o_st_be    = 4'b0011 << {i_st_addr_lo[1], 1'b0};
                o_st_wdata = {2{i_st_data[15:0]}};
            end
            MEM_W: begin
                o_st_be    = 4'b1111;
                o_st_wdata = i_st_data;
            end
            default: begin
                o_st_be    = 4'b0000;
                o_st_wdata = i_st_data;
            end
        endcase
    end

    // Load: the addressed byte/halfword now sits in the low bits; extend by size code.
    always_comb begin
        o_ld_data = w_shifted;
        case (i_ld_funct3)
            MEM_B:   o_ld_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            MEM_H:   o_ld_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            MEM_W:   o_ld_data = w_shifted;
            MEM_BU:  o_ld_data = {24'h000000, w_shifted[7:0]};
            MEM_HU:  o_ld_data = {16'h0000, w_shifted[15:0]};
            default: o_ld_data = w_shifted;
        endcase
    end
endmodule

// File: rtl/memory_stage_lsu_chk.sv
// Simulation checker for the data-memory handshake: a grant needs a live
// request, and read data needs a load the bus has accepted but not yet answered.
module memory_stage_lsu_chk (
    input logic clk,
    input logic rst_n,
    input logic i_req,
    input logic i_we,
    input logic i_gnt,
    input logic i_rvalid
);
    logic r_pending;

    // Bus-side view of an outstanding load; it survives rst_n because a flushed
    // load's response is still in flight at the memory and must be tolerated.
    always_ff @(posedge clk) begin
        if (i_rvalid) begin
            r_pending <= 1'b0;
        end else if (i_req && i_gnt && !i_we) begin
            r_pending <= 1'b1;
        end else begin
            r_pending <= r_pending;
        end
    end

    a_gnt_needs_req: assert property (@(posedge clk) disable iff (!rst_n) i_gnt |-> i_req);
    a_rvalid_needs_load: assert property (@(posedge clk) disable iff (!rst_n) i_rvalid |-> r_pending);
endmodule

// File: rtl/memory_stage_lsu.sv
// Memory stage of the RV32I pipeline: issues loads/stores on the req/gnt/rvalid
// bus, stalls the front of the pipe while an access is in flight, suppresses
// misaligned accesses, and registers the M->W boundary.
module memory_stage_lsu
    import pipeline_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int REG_ADDR = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                RegWriteM,
    input  logic [1:0]          ResultSrcM,
    input  logic                MemWriteM,
    input  logic [2:0]          Funct3M,
    input  logic [XLEN-1:0]     ALUResultM,
    input  logic [XLEN-1:0]     WriteDataM,
    input  logic [REG_ADDR-1:0] RdM,
    input  logic [XLEN-1:0]     PCPlus4M,
    memory_stage_lsu_if.master  dmem,
    output logic                StallM,
    output logic                MisalignM,
    output logic                RegWriteW,
    output logic [1:0]          ResultSrcW,
    output logic [XLEN-1:0]     ALUResultW,
    output logic [XLEN-1:0]     ReadDataW,
    output logic [REG_ADDR-1:0] RdW,
    output logic [XLEN-1:0]     PCPlus4W
);
    lsu_state_e  r_state;
    lsu_state_e  w_state_nxt;
    logic        w_mem_op;
    logic        w_misalign;
    logic        w_issue;
    logic        w_req;
    logic        w_stall;
    logic        w_ld_done;
    logic [1:0]  r_ld_off;
    logic [2:0]  r_ld_f3;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_ld_data;

    assign w_mem_op   = MemWriteM | (ResultSrcM == RES_LOAD);
    assign w_misalign = w_mem_op & is_misaligned(Funct3M, ALUResultM[1:0]);
    assign w_issue    = w_mem_op & ~w_misalign;

    lsu_align u_align (
        .i_st_funct3  (Funct3M),
        .i_st_addr_lo (ALUResultM[1:0]),
        .i_st_data    (WriteDataM),
        .o_st_be      (w_be),
        .o_st_wdata   (w_wdata),
        .i_ld_funct3  (r_ld_f3),
        .i_ld_addr_lo (r_ld_off),
        .i_ld_rdata   (dmem.dmem_rdata),
        .o_ld_data    (w_ld_data)
    );

    // Request fields come straight from the frozen E/M register, so they stay stable while stalled.
    assign dmem.dmem_req   = w_req;
    assign dmem.dmem_we    = MemWriteM;
    assign dmem.dmem_addr  = {ALUResultM[31:2], 2'b00};
    assign dmem.dmem_be    = w_be;
    assign dmem.dmem_wdata = w_wdata;
    assign StallM          = w_stall;

    // Handshake state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, request and stall: stall whenever an aligned access has not completed this cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_stall     = 1'b0;
        w_ld_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_issue) begin
                    w_req = 1'b1;
                    if (!dmem.dmem_gnt) begin
                        w_state_nxt = ST_WAIT_GNT;
                        w_stall     = 1'b1;
                    end else if (!MemWriteM) begin
                        w_state_nxt = ST_WAIT_RVALID;
                        w_stall     = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_GNT: begin
                w_req = 1'b1;
                if (!dmem.dmem_gnt) begin
                    w_stall = 1'b1;
                end else if (!MemWriteM) begin
                    w_state_nxt = ST_WAIT_RVALID;
                    w_stall     = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_RVALID: begin
                if (dmem.dmem_rvalid) begin
                    w_state_nxt = ST_IDLE;
                    w_ld_done   = 1'b1;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Remember offset and size of a granted load for extracting its response later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_off <= 2'b00;
            r_ld_f3  <= 3'b000;
        end else if (w_req && dmem.dmem_gnt && !MemWriteM) begin
            r_ld_off <= ALUResultM[1:0];
            r_ld_f3  <= Funct3M;
        end else begin
            r_ld_off <= r_ld_off;
            r_ld_f3  <= r_ld_f3;
        end
    end

    // M->W register: a bubble while stalled; a misaligned access passes with its write disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            RdW        <= '0;
            PCPlus4W   <= '0;
            MisalignM  <= 1'b0;
        end else if (w_stall) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            RdW        <= '0;
            PCPlus4W   <= '0;
            MisalignM  <= 1'b0;
        end else begin
            RegWriteW  <= RegWriteM & ~w_misalign;
            ResultSrcW <= ResultSrcM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= w_ld_done ? w_ld_data : 32'h0000_0000;
            RdW        <= RdM;
            PCPlus4W   <= PCPlus4M;
            MisalignM  <= w_misalign;
        end
    end

    memory_stage_lsu_chk u_chk (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (dmem.dmem_req),
        .i_we     (dmem.dmem_we),
        .i_gnt    (dmem.dmem_gnt),
        .i_rvalid (dmem.dmem_rvalid)
    );
endmodule
